regfile_wb: RTL

Architectural register file for the single-cycle processor. It sits directly downstream of `writebackmux` and consumes that mux's 32-bit `out` as its write data. It supplies the two source operands to the ALU/decode stage and exposes a debug read port and a write-event counter for bench and bring-up visibility. Register x0 reads as zero at all times.

---
 rtl/regfile_wb_if.sv | 29 ++
 rtl/regfile_wb.sv | 67 ++++++
 2 files changed

// File: rtl/regfile_wb_if.sv
// Register file bus: write port, two operand read ports, debug read and write counter.
// The master drives requests and the slave (regfile_wb) returns read data.
interface regfile_wb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rvalid1;
    logic              rvalid2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [31:0]       wcount;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, dbg_addr,
        input  rdata1, rdata2, rvalid1, rvalid2, dbg_data, wcount
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, dbg_addr,
        output rdata1, rdata2, rvalid1, rvalid2, dbg_data, wcount
    );
endinterface

// File: rtl/regfile_wb.sv
// Architectural register file with x0 hardwired to zero, optional write-first bypass,
// per-register written-since-reset flags, an unbypassed debug port and a saturating write counter.
module regfile_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_wb_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [1:DEPTH-1];
    logic [DEPTH-1:1]  r_valid;
    logic [31:0]       r_wcount;

    logic              w_wr_acc;
    logic [ADDR_W-1:0] w_raddr  [2];
    logic [DATA_W-1:0] w_rdata  [2];
    logic              w_rvalid [2];

    assign w_wr_acc = bus.we && (bus.waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid  <= '0;
            r_wcount <= '0;
        end else if (w_wr_acc) begin
            r_mem[bus.waddr]   <= bus.wdata;
            r_valid[bus.waddr] <= 1'b1;
            if (r_wcount != '1) begin
                r_wcount <= r_wcount + 32'd1;
            end
        end
    end

    assign w_raddr[0] = bus.raddr1;
    assign w_raddr[1] = bus.raddr2;

    // Each operand port resolves x0, bypass and stored value independently.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            w_rdata[p]  = '0;
            w_rvalid[p] = 1'b1;
            if (w_raddr[p] != '0) begin
                if (BYPASS && bus.we && (bus.waddr == w_raddr[p])) begin
                    w_rdata[p]  = bus.wdata;
                    w_rvalid[p] = 1'b1;
                end else begin
                    w_rdata[p]  = r_mem[w_raddr[p]];
                    w_rvalid[p] = r_valid[w_raddr[p]];
                end
            end
        end
    end

    assign bus.rdata1   = w_rdata[0];
    assign bus.rdata2   = w_rdata[1];
    assign bus.rvalid1  = w_rvalid[0];
    assign bus.rvalid2  = w_rvalid[1];
    assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : r_mem[bus.dbg_addr];
    assign bus.wcount   = r_wcount;
endmodule
